calc_entry_ctrl: RTL and testbench

- Keypad-to-operand sequencer for the calculator datapath.
- Accepts one-cycle key strobes and drives the button-to-number converter's `state`/`but_num` inputs, one digit per key.
- Finalizes each operand, waits for converter `complete`, and latches operand A, operator and operand B.
- Pulses `operands_valid` to the ALU stage when a full expression "A op B =" has been captured.

---
 rtl/calc_pkg.sv | 49 ++++
 rtl/calc_entry_ctrl_if.sv | 25 ++
 rtl/calc_key_filter.sv | 36 +++
 rtl/calc_entry_ctrl.sv | 152 +++++++++++++++
 tb/tb_calc_entry_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - key codes, converter commands, op codes and FSM states for calc_entry_ctrl
package calc_pkg;

  localparam logic [3:0] KEY_PLUS  = 4'hA;
  localparam logic [3:0] KEY_MINUS = 4'hB;
  localparam logic [3:0] KEY_MUL   = 4'hC;
  localparam logic [3:0] KEY_DIV   = 4'hD;
  localparam logic [3:0] KEY_EQ    = 4'hE;
  localparam logic [3:0] KEY_POINT = 4'hF;

  localparam logic [1:0] CONV_CLEAR = 2'b00;
  localparam logic [1:0] CONV_ENTER = 2'b01;
  localparam logic [1:0] CONV_HOLD  = 2'b10;
  localparam logic [1:0] CONV_FINAL = 2'b11;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ENTER_A,
    ST_FIN_A,
    ST_CLR,
    ST_ENTER_B,
    ST_FIN_B,
    ST_DONE,
    ST_ERR
  } state_t;

  function automatic logic is_entry_key(input logic [3:0] k);
    return (k <= 4'd9) || (k == KEY_POINT);
  endfunction

  function automatic logic is_op_key(input logic [3:0] k);
    return (k >= KEY_PLUS) && (k <= KEY_DIV);
  endfunction

  function automatic logic [1:0] op_of_key(input logic [3:0] k);
    case (k)
      KEY_MINUS: return OP_SUB;
      KEY_MUL:   return OP_MUL;
      KEY_DIV:   return OP_DIV;
      default:   return OP_ADD;
    endcase
  endfunction

endpackage

// File: rtl/calc_entry_ctrl_if.sv
// rtl/calc_entry_ctrl_if.sv - keypad, converter and ALU-side signals of calc_entry_ctrl
interface calc_entry_ctrl_if;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [31:0] conv_result;
  logic        conv_complete;
  logic [1:0]  conv_state;
  logic [3:0]  conv_num;
  logic [31:0] opnd_a;
  logic [31:0] opnd_b;
  logic [1:0]  op_code;
  logic        operands_valid;
  logic        busy;
  logic        err;

  modport master (
    output key_valid, key_code, conv_result, conv_complete,
    input  conv_state, conv_num, opnd_a, opnd_b, op_code, operands_valid, busy, err
  );

  modport slave (
    input  key_valid, key_code, conv_result, conv_complete,
    output conv_state, conv_num, opnd_a, opnd_b, op_code, operands_valid, busy, err
  );
endinterface

// File: rtl/calc_key_filter.sv
// rtl/calc_key_filter.sv - per-operand digit limit and single decimal point filter
module calc_key_filter
  import calc_pkg::*;
#(
  parameter int MAX_DIGITS = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       enable,
  input  logic [3:0] key_code,
  output logic       forward,
  output logic       has_digits
);
  localparam int CW = $clog2(MAX_DIGITS + 1);

  logic [CW-1:0] count;
  logic          point_seen;
  logic          is_point;

  assign is_point   = (key_code == KEY_POINT);
  assign has_digits = (count != '0);
  // A repeated point is dropped without consuming a digit slot.
  assign forward    = enable && is_entry_key(key_code) && (count < CW'(MAX_DIGITS))
                      && !(is_point && point_seen);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count      <= '0;
      point_seen <= 1'b0;
    end else if (forward) begin
      count <= count + 1'b1;
      if (is_point) point_seen <= 1'b1;
    end
  end
endmodule

// File: rtl/calc_entry_ctrl.sv
// rtl/calc_entry_ctrl.sv - keypad-to-operand sequencer driving the button-to-number converter
module calc_entry_ctrl
  import calc_pkg::*;
#(
  parameter int MAX_DIGITS   = 9,
  parameter int CONV_TIMEOUT = 64
) (
  input logic               clk,
  input logic               rst,
  calc_entry_ctrl_if.slave  bus
);
  localparam int TW = $clog2(CONV_TIMEOUT + 1);

  state_t        state, state_nxt;
  logic [1:0]    conv_state_q, conv_state_nxt;
  logic [3:0]    conv_num_q, conv_num_nxt;
  logic [31:0]   opnd_a_q, opnd_a_nxt, opnd_b_q, opnd_b_nxt;
  logic [1:0]    op_code_q, op_code_nxt;
  logic          valid_q, valid_nxt, busy_q, busy_nxt, err_q, err_nxt;
  logic [TW-1:0] tmo_q, tmo_nxt;
  logic          fwd, has_digits, flt_enable, flt_clear;

  assign flt_enable = bus.key_valid && (state inside {ST_IDLE, ST_ENTER_A, ST_ENTER_B});
  // Clearing in DONE/ERR leaves the filter empty for the first key seen in IDLE.
  assign flt_clear  = state inside {ST_CLR, ST_DONE, ST_ERR};

  calc_key_filter #(.MAX_DIGITS(MAX_DIGITS)) u_filter (
    .clk        (clk),
    .rst        (rst),
    .clear      (flt_clear),
    .enable     (flt_enable),
    .key_code   (bus.key_code),
    .forward    (fwd),
    .has_digits (has_digits)
  );

  always_comb begin
    state_nxt      = state;
    conv_state_nxt = CONV_HOLD;
    conv_num_nxt   = conv_num_q;
    opnd_a_nxt     = opnd_a_q;
    opnd_b_nxt     = opnd_b_q;
    op_code_nxt    = op_code_q;
    valid_nxt      = 1'b0;
    err_nxt        = 1'b0;
    tmo_nxt        = '0;
    case (state)
      ST_IDLE: begin
        conv_state_nxt = CONV_CLEAR;
        if (fwd) begin
          state_nxt      = ST_ENTER_A;
          conv_state_nxt = CONV_ENTER;
          conv_num_nxt   = bus.key_code;
        end
      end
      ST_ENTER_A: begin
        if (fwd) begin
          conv_state_nxt = CONV_ENTER;
          conv_num_nxt   = bus.key_code;
        end else if (bus.key_valid && is_op_key(bus.key_code) && has_digits) begin
          op_code_nxt    = op_of_key(bus.key_code);
          state_nxt      = ST_FIN_A;
          conv_state_nxt = CONV_FINAL;
        end
      end
      ST_ENTER_B: begin
        if (fwd) begin
          conv_state_nxt = CONV_ENTER;
          conv_num_nxt   = bus.key_code;
        end else if (bus.key_valid && (bus.key_code == KEY_EQ) && has_digits) begin
          state_nxt      = ST_FIN_B;
          conv_state_nxt = CONV_FINAL;
        end
      end
      ST_FIN_A, ST_FIN_B: begin
        conv_state_nxt = CONV_FINAL;
        tmo_nxt        = tmo_q + 1'b1;
        // Completion is checked first so it wins over an expiring timeout.
        if (bus.conv_complete) begin
          tmo_nxt        = '0;
          conv_state_nxt = CONV_CLEAR;
          if (state == ST_FIN_A) begin
            opnd_a_nxt = bus.conv_result;
            state_nxt  = ST_CLR;
          end else begin
            opnd_b_nxt = bus.conv_result;
            valid_nxt  = 1'b1;
            state_nxt  = ST_DONE;
          end
        end else if (tmo_q == TW'(CONV_TIMEOUT - 1)) begin
          tmo_nxt        = '0;
          conv_state_nxt = CONV_CLEAR;
          err_nxt        = 1'b1;
          state_nxt      = ST_ERR;
        end
      end
      ST_CLR: state_nxt = ST_ENTER_B;
      ST_DONE: begin
        conv_state_nxt = CONV_CLEAR;
        state_nxt      = ST_IDLE;
      end
      ST_ERR: begin
        conv_state_nxt = CONV_CLEAR;
        err_nxt        = 1'b1;
        if (bus.key_valid) begin
          err_nxt   = 1'b0;
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        conv_state_nxt = CONV_CLEAR;
        state_nxt      = ST_IDLE;
      end
    endcase
    busy_nxt = state_nxt inside {ST_FIN_A, ST_CLR, ST_FIN_B, ST_DONE};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      conv_state_q <= CONV_CLEAR;
      conv_num_q   <= '0;
      opnd_a_q     <= '0;
      opnd_b_q     <= '0;
      op_code_q    <= OP_ADD;
      valid_q      <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
      tmo_q        <= '0;
    end else begin
      state        <= state_nxt;
      conv_state_q <= conv_state_nxt;
      conv_num_q   <= conv_num_nxt;
      opnd_a_q     <= opnd_a_nxt;
      opnd_b_q     <= opnd_b_nxt;
      op_code_q    <= op_code_nxt;
      valid_q      <= valid_nxt;
      busy_q       <= busy_nxt;
      err_q        <= err_nxt;
      tmo_q        <= tmo_nxt;
    end
  end

  assign bus.conv_state     = conv_state_q;
  assign bus.conv_num       = conv_num_q;
  assign bus.opnd_a         = opnd_a_q;
  assign bus.opnd_b         = opnd_b_q;
  assign bus.op_code        = op_code_q;
  assign bus.operands_valid = valid_q;
  assign bus.busy           = busy_q;
  assign bus.err            = err_q;
endmodule

// File: tb/tb_calc_entry_ctrl.sv
// tb/tb_calc_entry_ctrl.sv - self-checking bench for calc_entry_ctrl
module tb_calc_entry_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  calc_entry_ctrl_if bus();

  calc_entry_ctrl #(.MAX_DIGITS(9), .CONV_TIMEOUT(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Converter stand-in: completes a fixed or random number of cycles into each finalize.
  logic [31:0] res_mem [0:1023];
  int  res_wr = 0;
  int  res_rd = 0;
  int  fin_cnt = 0;
  int  cur_delay = 0;
  int  fixed_delay = 4;
  bit  rand_delay = 0;
  bit  conv_never = 0;
  bit  spurious_en = 0;

  always @(negedge clk) begin
    if (bus.conv_state == 2'b11) begin
      if (fin_cnt == 0) cur_delay = rand_delay ? int'($urandom_range(0, 8)) : fixed_delay;
      if (!conv_never && fin_cnt == cur_delay) begin
        bus.conv_complete = 1'b1;
        bus.conv_result   = res_mem[res_rd];
        res_rd++;
      end else begin
        bus.conv_complete = 1'b0;
      end
      fin_cnt++;
    end else begin
      fin_cnt = 0;
      bus.conv_complete = spurious_en && ($urandom_range(0, 3) == 0);
      bus.conv_result   = $urandom;
    end
  end

  logic [3:0]  fwd_log [$];
  logic [65:0] val_log [$];
  always @(negedge clk) begin
    if (bus.conv_state == 2'b01) fwd_log.push_back(bus.conv_num);
    if (bus.operands_valid) val_log.push_back({bus.opnd_a, bus.op_code, bus.opnd_b});
  end

  task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic press(input logic [3:0] k);
    bus.key_valid = 1'b1;
    bus.key_code  = k;
    @(negedge clk);
    bus.key_valid = 1'b0;
  endtask

  task automatic wait_idle;
    int n = 0;
    while (bus.busy !== 1'b0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      checks++;
      failures++;
      $display("FAIL wait_idle busy still high after %0d cycles", n);
    end
  endtask

  task automatic do_reset;
    rst = 1'b1;
    bus.key_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic push_res(input logic [31:0] r);
    res_mem[res_wr] = r;
    res_wr++;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_conv_state"}, bus.conv_state, 0);
    check({tag, "_conv_num"}, bus.conv_num, 0);
    check({tag, "_opnd_a"}, bus.opnd_a, 0);
    check({tag, "_opnd_b"}, bus.opnd_b, 0);
    check({tag, "_op_code"}, bus.op_code, 0);
    check({tag, "_valid"}, bus.operands_valid, 0);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_err"}, bus.err, 0);
  endtask

  function automatic logic [3:0] fwd_at(input int idx);
    return (idx < fwd_log.size()) ? fwd_log[idx] : 4'hx;
  endfunction

  typedef struct {
    logic [3:0] key;
    logic [1:0] exp_cs;
    logic [3:0] exp_num;
  } vec_t;

  vec_t tbl [13];

  initial begin
    watchdog();
  end

  task automatic watchdog;
    #400000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  endtask

  initial begin
    int fb, vb, n, phase, cnt;
    bit pt;
    logic [3:0] k, d;
    logic [31:0] r, exp_a;
    logic [1:0] exp_op;
    logic [3:0]  exp_fwd [$];
    logic [65:0] exp_rec [$];
    int exp_tbl [5] = '{2, 4, 15, 5, 9};

    bus.key_valid = 1'b0;
    bus.key_code  = 4'h0;
    do_reset();
    check_reset_outputs("reset");

    // Main expression 24.5 + 9 with ignored keys in every entry phase.
    tbl[0]  = '{4'hA, 2'b00, 4'h0};
    tbl[1]  = '{4'hE, 2'b00, 4'h0};
    tbl[2]  = '{4'h2, 2'b01, 4'h2};
    tbl[3]  = '{4'hE, 2'b10, 4'h0};
    tbl[4]  = '{4'h4, 2'b01, 4'h4};
    tbl[5]  = '{4'hF, 2'b01, 4'hF};
    tbl[6]  = '{4'hF, 2'b10, 4'h0};
    tbl[7]  = '{4'h5, 2'b01, 4'h5};
    tbl[8]  = '{4'hA, 2'b11, 4'h0};
    tbl[9]  = '{4'hA, 2'b10, 4'h0};
    tbl[10] = '{4'hE, 2'b10, 4'h0};
    tbl[11] = '{4'h9, 2'b01, 4'h9};
    tbl[12] = '{4'hE, 2'b11, 4'h0};
    fixed_delay = 4;
    push_res(32'h0000_0F5A);
    push_res(32'h0000_0009);
    fb = fwd_log.size();
    vb = val_log.size();
    for (int i = 0; i < 13; i++) begin
      press(tbl[i].key);
      check($sformatf("tbl%0d_conv_state", i), bus.conv_state, tbl[i].exp_cs);
      if (tbl[i].exp_cs == 2'b01) check($sformatf("tbl%0d_conv_num", i), bus.conv_num, tbl[i].exp_num);
      wait_idle();
      repeat (3) @(negedge clk);
    end
    check("tbl_opnd_a", bus.opnd_a, 32'h0000_0F5A);
    check("tbl_op_code", bus.op_code, 2'b00);
    check("tbl_opnd_b", bus.opnd_b, 32'h0000_0009);
    check("tbl_valid_pulses", val_log.size() - vb, 1);
    check("tbl_fwd_count", fwd_log.size() - fb, 5);
    for (int i = 0; i < 5; i++) check($sformatf("tbl_fwd%0d", i), fwd_at(fb + i), exp_tbl[i]);

    // Digit limit on A, point-once and fresh counters on B.
    push_res(32'h1234_5678);
    push_res(32'h0000_0003);
    fb = fwd_log.size();
    vb = val_log.size();
    for (int i = 0; i < 10; i++) begin
      press(4'((i + 1) % 10));
      repeat (3) @(negedge clk);
    end
    check("limit_fwd_count", fwd_log.size() - fb, 9);
    for (int i = 0; i < 9; i++) check($sformatf("limit_fwd%0d", i), fwd_at(fb + i), i + 1);
    press(4'hB);
    check("limit_fin_a", bus.conv_state, 2'b11);
    wait_idle();
    fb = fwd_log.size();
    press(4'hF); press(4'h3); press(4'hF);
    repeat (3) @(negedge clk);
    check("point_fwd_count", fwd_log.size() - fb, 2);
    check("point_fwd0", fwd_at(fb), 4'hF);
    check("point_fwd1", fwd_at(fb + 1), 4'h3);
    press(4'hE);
    wait_idle();
    repeat (2) @(negedge clk);
    check("limit_expr", val_log.size() > vb ? val_log[vb] : 66'hx, {32'h1234_5678, 2'b01, 32'h3});

    // Converter timeout in FIN_A.
    conv_never = 1;
    press(4'h1);
    press(4'hA);
    check("tmo_fin_a", bus.conv_state, 2'b11);
    n = 0;
    while (bus.err !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("tmo_cycles", n, 64);
    check("tmo_conv_state", bus.conv_state, 2'b00);
    check("tmo_busy", bus.busy, 0);
    check("tmo_opnd_a_kept", bus.opnd_a, 32'h1234_5678);
    conv_never = 0;
    press(4'h5);
    check("tmo_err_cleared", bus.err, 0);
    check("tmo_key_discarded", bus.conv_state, 2'b00);
    repeat (2) @(negedge clk);
    press(4'h5);
    check("tmo_idle_cs", bus.conv_state, 2'b01);
    check("tmo_idle_num", bus.conv_num, 4'h5);

    // Reset in the middle of FIN_B.
    do_reset();
    push_res(32'hAAAA_0001);
    press(4'h1); press(4'hA);
    wait_idle();
    press(4'h2);
    conv_never = 1;
    press(4'hE);
    check("rst_fin_b", bus.conv_state, 2'b11);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_outputs("midrst");
    conv_never = 0;
    press(4'h7);
    check("midrst_cs", bus.conv_state, 2'b01);
    check("midrst_num", bus.conv_num, 4'h7);

    // Keys during FIN_A are dropped and not replayed after CLR.
    do_reset();
    fixed_delay = 10;
    push_res(32'h0000_0055);
    press(4'h3); press(4'hB);
    fb = fwd_log.size();
    press(4'h4); press(4'h5);
    wait_idle();
    repeat (4) @(negedge clk);
    check("drop_fwd_count", fwd_log.size() - fb, 0);
    check("drop_enter_b", bus.conv_state, 2'b10);
    check("drop_op_code", bus.op_code, 2'b01);
    check("drop_opnd_a", bus.opnd_a, 32'h0000_0055);

    // Random key stream against a key-level model of operand entry.
    do_reset();
    rand_delay = 1;
    spurious_en = 1;
    fb = fwd_log.size();
    vb = val_log.size();
    phase = 0; cnt = 0; pt = 0; exp_a = 0; exp_op = 0;
    for (int i = 0; i < 250; i++) begin
      k = 4'($urandom_range(0, 15));
      if (k <= 4'd9 || k == 4'hF) begin
        if (cnt < 9 && !(k == 4'hF && pt)) begin
          exp_fwd.push_back(k);
          cnt++;
          if (k == 4'hF) pt = 1;
          if (phase == 0) phase = 1;
        end
      end else if (phase == 1 && k <= 4'hD && cnt > 0) begin
        d = k - 4'hA;
        exp_op = d[1:0];
        exp_a = $urandom;
        push_res(exp_a);
        phase = 2; cnt = 0; pt = 0;
      end else if (phase == 2 && k == 4'hE && cnt > 0) begin
        r = $urandom;
        push_res(r);
        exp_rec.push_back({exp_a, exp_op, r});
        phase = 0; cnt = 0; pt = 0;
      end
      press(k);
      wait_idle();
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    repeat (3) @(negedge clk);
    check("rand_fwd_count", fwd_log.size() - fb, exp_fwd.size());
    for (int i = 0; i < exp_fwd.size(); i++)
      if (fwd_at(fb + i) !== exp_fwd[i]) check($sformatf("rand_fwd%0d", i), fwd_at(fb + i), exp_fwd[i]);
    check("rand_expr_count", val_log.size() - vb, exp_rec.size());
    for (int i = 0; i < exp_rec.size(); i++)
      check($sformatf("rand_expr%0d", i), (vb + i < val_log.size()) ? val_log[vb + i] : 66'hx, exp_rec[i]);
    check("rand_no_err", bus.err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
